reg_pwm_generator: RTL and testbench

//  Multi-channel PWM generator that consumes the flattened register vector of a memory-mapped register bank.
//  It sits downstream of that bank: word 0 = control, word 1 = period, word 2+k = duty for channel k.

---
 rtl/reg_pwm_generator.sv | 167 ++++++++++++++++
 tb/tb_reg_pwm_generator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pwm_generator.sv
// ---------------------------------------------------------------------------
// reg_pwm_generator
//
// Multi-channel PWM generator. It reads the flattened register vector of an
// upstream memory-mapped register bank:
//   word 0       control: bit0 enable, bit1 invert (other bits ignored)
//   word 1       period   (low CNT_WIDTH bits used)
//   word 2+k     duty of channel k (low CNT_WIDTH bits used)
// Period, duties and invert are copied into shadow registers at enable and
// at every period boundary. A CPU write therefore never changes a period
// that is already in progress.
//
// Optional feature: define REG_PWM_IRQ_EN to build a sticky period
// interrupt. If it is not defined, irq is tied low and irq_clear is ignored.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high; clears every flop
//   register     in   DATA_WIDTH*(NUM_CHANNELS+2) flattened register words
//   pwm_out      out  NUM_CHANNELS registered PWM outputs
//   period_done  out  one-cycle pulse on the last cycle of each period
//   counter      out  current position inside the period
//   irq          out  sticky period interrupt
//   irq_clear    in   clears irq; if it coincides with a set, the set wins
// ---------------------------------------------------------------------------
module reg_pwm_generator #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_CHANNELS = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [DATA_WIDTH*(NUM_CHANNELS+2)-1:0] register,
   output logic [NUM_CHANNELS-1:0]                pwm_out,
   output logic                                   period_done,
   output logic [CNT_WIDTH-1:0]                   counter,
   output logic                                   irq,
   input  logic                                   irq_clear
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state;
   state_t                 state_next;

   // Fields decoded from the live register words
   logic                   enable;
   logic                   invert;
   logic [CNT_WIDTH-1:0]   period_word;
   logic [CNT_WIDTH-1:0]   duty_word [NUM_CHANNELS];

   // Shadow copies that control the current period
   logic [CNT_WIDTH-1:0]   period_s;
   logic [CNT_WIDTH-1:0]   duty_s [NUM_CHANNELS];
   logic                   inv_s;

   logic                   load;
   logic                   wrap;
   logic                   running;
   logic [NUM_CHANNELS-1:0] pwm_next;

   // Control bits above bit1 and period/duty bits above CNT_WIDTH are
   // ignored on purpose. This reduction marks them as intentionally unused.
   logic                   unused_bits;
   assign unused_bits = ^{register, irq_clear};

   assign enable      = register[0];
   assign invert      = register[1];
   assign period_word = register[DATA_WIDTH +: CNT_WIDTH];

   always_comb begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         duty_word[k] = register[(k+2)*DATA_WIDTH +: CNT_WIDTH];
      end
   end

   // ---- FSM: state register ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---- FSM: next state, shadow reload and period wrap ----
   always_comb begin
      state_next = state;
      load       = 1'b0;
      wrap       = 1'b0;
      if (state == IDLE) begin
         if (enable) begin
            state_next = RUN;
            load       = 1'b1;
         end
      end else begin
         if (!enable) begin
            state_next = IDLE;
         end else if (counter == period_s) begin
            wrap = 1'b1;
            load = 1'b1;
         end
      end
   end

   assign running = (state == RUN) && enable;

   // Compare against the counter value before the edge, so pwm_out lags
   // the counter by one cycle. IDLE and a falling enable force the outputs low.
   always_comb begin
      pwm_next = '0;
      if (running) begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            pwm_next[k] = (counter < duty_s[k]) ^ inv_s;
         end
      end
   end

   // ---- counter, outputs and shadow registers ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         counter     <= '0;
         period_done <= 1'b0;
         pwm_out     <= '0;
         period_s    <= '0;
         inv_s       <= 1'b0;
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            duty_s[k] <= '0;
         end
      end else begin
         // The counter restarts on a wrap, in IDLE and when enable drops.
         // It never passes period_s, so it cannot overflow.
         if (running && !wrap) begin
            counter <= counter + 1'b1;
         end else begin
            counter <= '0;
         end
         period_done <= wrap;
         pwm_out     <= pwm_next;
         // A register write on the reload edge is captured by that reload.
         if (load) begin
            period_s <= period_word;
            inv_s    <= invert;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
               duty_s[k] <= duty_word[k];
            end
         end
      end
   end

`ifdef REG_PWM_IRQ_EN
   // Sticky interrupt. A set on the same edge as a clear takes priority,
   // and the value is kept while the FSM is in IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         irq <= 1'b0;
      end else if (wrap) begin
         irq <= 1'b1;
      end else if (irq_clear) begin
         irq <= 1'b0;
      end
   end
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_reg_pwm_generator.sv
// ---------------------------------------------------------------------------
// tb_reg_pwm_generator
//
// Scoreboard bench for reg_pwm_generator. The stimulus drives the register
// words (with random junk in the ignored bits) on the falling edge. It steps
// a period-level reference model and queues the outputs expected after the
// next rising edge. A separate monitor pops one entry per cycle and compares
// it with the DUT outputs. The bench works with or without REG_PWM_IRQ_EN.
// ---------------------------------------------------------------------------
module tb_reg_pwm_generator;

   localparam int DW = 32;
   localparam int NC = 2;
   localparam int CW = 16;

   logic                 clock;
   logic                 reset;
   logic [DW*(NC+2)-1:0] register;
   logic [NC-1:0]        pwm_out;
   logic                 period_done;
   logic [CW-1:0]        counter;
   logic                 irq;
   logic                 irq_clear;

   reg_pwm_generator #(
      .DATA_WIDTH  (DW),
      .NUM_CHANNELS(NC),
      .CNT_WIDTH   (CW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .register   (register),
      .pwm_out    (pwm_out),
      .period_done(period_done),
      .counter    (counter),
      .irq        (irq),
      .irq_clear  (irq_clear)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [NC-1:0] pwm;
      logic          pd;
      logic [CW-1:0] cnt;
      logic          irq;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int errors = 0;

   // Register-bank contents as the CPU sees them
   bit            reg_en  = 1'b0;
   bit            reg_inv = 1'b0;
   bit [CW-1:0]   reg_p   = '0;
   bit [CW-1:0]   reg_d [NC];
   bit            clr     = 1'b0;

   // Reference model: the settings latched for the current period and
   // the position inside it
   bit            m_run = 1'b0;
   int            m_pos = 0;
   int            m_len = 1;
   int            m_high [NC];
   bit            m_inv = 1'b0;
   bit            m_irq = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic drive_regs();
      logic [DW-1:0] w;
      w = $urandom; w[0] = reg_en; w[1] = reg_inv;
      register[0 +: DW] = w;
      w = $urandom; w[CW-1:0] = reg_p;
      register[DW +: DW] = w;
      for (int k = 0; k < NC; k++) begin
         w = $urandom; w[CW-1:0] = reg_d[k];
         register[(k+2)*DW +: DW] = w;
      end
   endtask

   // A new period takes the length, the high times and the polarity from
   // the current register contents. The high time is capped at the period length.
   task automatic start_period();
      m_len = int'(reg_p) + 1;
      for (int k = 0; k < NC; k++) begin
         m_high[k] = (int'(reg_d[k]) < m_len) ? int'(reg_d[k]) : m_len;
      end
      m_inv = reg_inv;
      m_pos = 0;
   endtask

   task automatic model_step();
      exp_t e;
      e.pwm = '0;
      e.pd  = 1'b0;
      if (!m_run) begin
         if (reg_en) begin
            m_run = 1'b1;
            start_period();
         end
      end else if (!reg_en) begin
         m_run = 1'b0;
         m_pos = 0;
      end else begin
         for (int k = 0; k < NC; k++) begin
            e.pwm[k] = (m_pos < m_high[k]) ^ m_inv;
         end
         if (m_pos == m_len - 1) begin
            e.pd = 1'b1;
            start_period();
         end else begin
            m_pos++;
         end
      end
`ifdef REG_PWM_IRQ_EN
      if (e.pd) m_irq = 1'b1;
      else if (irq_clear) m_irq = 1'b0;
`else
      m_irq = 1'b0;
`endif
      e.cnt = CW'(m_pos);
      e.irq = m_irq;
      q.push_back(e);
   endtask

   task automatic cycle();
      @(negedge clock);
      drive_regs();
      irq_clear = clr;
      model_step();
   endtask

   // Run until the next rising edge will see the given period position.
   task automatic run_to_pos(input int pos);
      for (int i = 0; i < 40 && !(m_run && m_pos == pos); i++) cycle();
   endtask

   task automatic async_reset_check();
      @(negedge clock);
      #1 reset = 1'b1;
      #1;
      check("rst_mid_pwm", 32'(pwm_out), 32'd0);
      check("rst_mid_pd", 32'(period_done), 32'd0);
      check("rst_mid_counter", 32'(counter), 32'd0);
      check("rst_mid_irq", 32'(irq), 32'd0);
      m_run = 1'b0; m_pos = 0; m_irq = 1'b0;
      reg_en = 1'b0; clr = 1'b0; irq_clear = 1'b0;
      drive_regs();
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // Monitor: one comparison set per rising edge while entries are queued
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pwm_out", 32'(pwm_out), 32'(e.pwm));
            check("period_done", 32'(period_done), 32'(e.pd));
            check("counter", 32'(counter), 32'(e.cnt));
            check("irq", 32'(irq), 32'(e.irq));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < NC; k++) reg_d[k] = '0;
      reset = 1'b1;
      irq_clear = 1'b0;
      drive_regs();
      repeat (3) @(negedge clock);
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_pd", 32'(period_done), 32'd0);
      check("rst_counter", 32'(counter), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;

      // Basic waveform, then a channel that is always high or always low
      reg_en = 1; reg_inv = 0; reg_p = 4; reg_d[0] = 2; reg_d[1] = 0;
      repeat (20) cycle();
      reg_d[0] = 5;             repeat (12) cycle();
      reg_inv = 1;              repeat (12) cycle();
      reg_d[0] = 0;             repeat (12) cycle();

      // Mid-period duty write only affects later periods
      reg_inv = 0; reg_d[0] = 2;
      repeat (10) cycle();
      run_to_pos(1);
      reg_d[0] = 3;
      repeat (16) cycle();

      // Zero period
      reg_p = 0; reg_d[0] = 1;
      repeat (10) cycle();

      // Enable dropped mid-period, restart, then async reset mid-run
      reg_p = 4; reg_d[0] = 2;
      repeat (8) cycle();
      run_to_pos(2);
      reg_en = 0;  repeat (4) cycle();
      reg_en = 1;  repeat (8) cycle();
      async_reset_check();
      reg_en = 1;  repeat (10) cycle();

      // Interrupt: clear together with a set, then clear on its own
      run_to_pos(int'(reg_p));
      clr = 1; cycle(); clr = 0;
      repeat (2) cycle();
      clr = 1; cycle(); clr = 0;
      repeat (4) cycle();

      // Randomised traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 39) == 0) reg_en = ~reg_en;
         if ($urandom_range(0, 5) == 0) begin
            reg_p = CW'($urandom_range(0, 7));
            for (int k = 0; k < NC; k++) reg_d[k] = CW'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) reg_inv = ~reg_inv;
         end
         clr = ($urandom_range(0, 7) == 0);
         cycle();
      end
      clr = 0;

      repeat (3) @(posedge clock);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d entries, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
